// File: rtl/maxpool_layer1.sv
// 2x2 stride-2 signed max pooling from layer 0 (csel=1) into layer 1 (csel=3).
// One window per six cycles: four reads, one drain for the read latency, one write.
module maxpool_layer1 #(
  parameter int IMG_W  = 64,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     crd,
  output logic [ADDR_W-1:0]        caddr_rd,
  input  logic signed [DATA_W-1:0] cdata_rd,
  output logic                     cwr,
  output logic [ADDR_W-1:0]        caddr_wr,
  output logic signed [DATA_W-1:0] cdata_wr,
  output logic [2:0]               csel
);

  localparam int CW = $clog2(IMG_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DRAIN  = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                   state, state_next;
  logic [1:0]               rd_cnt, rd_cnt_next;
  logic [CW-1:0]            ox, oy, ox_next, oy_next;
  logic signed [DATA_W-1:0] max_val, max_next;
  logic                     last_win;
  logic                     capture, first_sample;

  logic                     busy_d, done_d, crd_d, cwr_d;
  logic [2:0]               csel_d;
  logic [ADDR_W-1:0]        caddr_rd_d, caddr_wr_d;
  logic signed [DATA_W-1:0] cdata_wr_d;

  // State register, window coordinates and running maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_cnt  <= 2'd0;
      ox      <= '0;
      oy      <= '0;
      max_val <= '0;
    end else begin
      state   <= state_next;
      rd_cnt  <= rd_cnt_next;
      ox      <= ox_next;
      oy      <= oy_next;
      max_val <= max_next;
    end
  end

  assign last_win = (&ox) & (&oy);

  // Next-state logic; coordinates advance as each window is written.
  always_comb begin
    state_next  = state;
    rd_cnt_next = rd_cnt;
    ox_next     = ox;
    oy_next     = oy;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next  = S_READ;
          rd_cnt_next = 2'd0;
          ox_next     = '0;
          oy_next     = '0;
        end
      end
      S_READ: begin
        rd_cnt_next = rd_cnt + 2'd1;
        if (rd_cnt == 2'd3) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_WRITE;
      S_WRITE: begin
        state_next  = last_win ? S_FINISH : S_READ;
        rd_cnt_next = 2'd0;
        ox_next     = ox + 1'b1;
        if (&ox) oy_next = oy + 1'b1;
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Read data trails its address by one cycle, so samples land in READ 1..3 and DRAIN.
  assign capture      = ((state == S_READ) && (rd_cnt != 2'd0)) || (state == S_DRAIN);
  assign first_sample = (state == S_READ) && (rd_cnt == 2'd1);

  always_comb begin
    max_next = max_val;
    if (capture && (first_sample || (cdata_rd > max_val))) max_next = cdata_rd;
  end

  // Output decode: values for the upcoming cycle, registered below.
  always_comb begin
    busy_d     = (state_next == S_READ) || (state_next == S_DRAIN) || (state_next == S_WRITE);
    done_d     = (state_next == S_FINISH);
    crd_d      = (state_next == S_READ);
    cwr_d      = (state_next == S_WRITE);
    csel_d     = 3'd0;
    caddr_rd_d = caddr_rd;
    caddr_wr_d = caddr_wr;
    cdata_wr_d = cdata_wr;
    if (state_next == S_READ) begin
      csel_d     = 3'd1;
      caddr_rd_d = {oy_next, rd_cnt_next[1], ox_next, rd_cnt_next[0]};
    end
    if (state_next == S_WRITE) begin
      csel_d     = 3'd3;
      caddr_wr_d = ADDR_W'({oy, ox});
      cdata_wr_d = max_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'd0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      crd      <= crd_d;
      cwr      <= cwr_d;
      csel     <= csel_d;
      caddr_rd <= caddr_rd_d;
      caddr_wr <= caddr_wr_d;
      cdata_wr <= cdata_wr_d;
    end
  end

endmodule

// File: tb/tb_maxpool_layer1.sv
// Bench for maxpool_layer1: layer-0 memory model, frame-timeline reference model,
// per-cycle output compare and directed/random frames.
module tb_maxpool_layer1;

  localparam int FRAME_LAST = 6143;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               busy, done, crd, cwr;
  logic [11:0]        caddr_rd, caddr_wr;
  logic signed [19:0] cdata_rd = '0;
  logic signed [19:0] cdata_wr;
  logic [2:0]         csel;

  logic [19:0] mem[4096];
  logic [19:0] layer1[1024];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t = -1;
  int frame_start = 0;
  logic [11:0] m_caddr_rd = '0;
  logic [11:0] m_caddr_wr = '0;
  logic [19:0] m_cdata_wr = '0;

  int wr_count, rd_count, first_wr_cyc, done_cyc;
  bit done_seen;
  logic [11:0] first4[4];
  logic [11:0] last4[4];
  logic [11:0] last_wr_addr;
  logic [19:0] last_wr_data;

  maxpool_layer1 dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  // Layer-0 memory: one cycle of read latency.
  always @(posedge clk) cdata_rd <= mem[caddr_rd];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [19:0] window_max(input int w);
    int ox, oy, a;
    logic signed [19:0] v[4];
    logic signed [19:0] m;
    ox = w % 32;
    oy = w / 32;
    a = oy * 128 + ox * 2;
    v[0] = mem[a]; v[1] = mem[a + 1]; v[2] = mem[a + 64]; v[3] = mem[a + 65];
    m = v[0];
    for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
    return m;
  endfunction

  // Reference model: position t on the frame timeline (-1 = idle).
  always @(posedge clk) begin
    int w, p;
    cyc++;
    if (reset) begin
      t = -1;
      m_caddr_rd = '0;
      m_caddr_wr = '0;
      m_cdata_wr = '0;
    end else if (t < 0) begin
      if (start) begin
        t = 0;
        frame_start = cyc;
      end
    end else if (t == FRAME_LAST + 1) begin
      t = -1;
    end else begin
      t++;
    end
    if (t >= 0 && t <= FRAME_LAST) begin
      w = t / 6;
      p = t % 6;
      if (p < 4) m_caddr_rd = 12'((2 * (w / 32) + p / 2) * 64 + 2 * (w % 32) + p % 2);
      if (p == 5) begin
        m_caddr_wr = 12'(w);
        m_cdata_wr = window_max(w);
      end
    end
  end

  // Compare process, away from the active edge.
  always @(posedge clk) begin
    bit act;
    int p;
    logic [2:0] e_csel;
    #3;
    act = (t >= 0 && t <= FRAME_LAST);
    p = act ? t % 6 : 0;
    e_csel = (act && p < 4) ? 3'd1 : (act && p == 5) ? 3'd3 : 3'd0;
    chk("busy", 32'(busy), 32'(act));
    chk("done", 32'(done), 32'(t == FRAME_LAST + 1));
    chk("crd", 32'(crd), 32'(act && p < 4));
    chk("cwr", 32'(cwr), 32'(act && p == 5));
    chk("csel", 32'(csel), 32'(e_csel));
    chk("caddr_rd", 32'(caddr_rd), 32'(m_caddr_rd));
    chk("caddr_wr", 32'(caddr_wr), 32'(m_caddr_wr));
    chk("cdata_wr", {12'd0, cdata_wr}, {12'd0, m_cdata_wr});
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc = cyc;
    end
    if (cwr === 1'b1) begin
      layer1[caddr_wr[9:0]] = cdata_wr;
      if (wr_count == 0) first_wr_cyc = cyc;
      wr_count++;
      last_wr_addr = caddr_wr;
      last_wr_data = cdata_wr;
    end
    if (crd === 1'b1) begin
      if (rd_count < 4) first4[rd_count] = caddr_rd;
      for (int k = 0; k < 3; k++) last4[k] = last4[k + 1];
      last4[3] = caddr_rd;
      rd_count++;
    end
  end

  task automatic clear_log();
    wr_count = 0;
    rd_count = 0;
    done_seen = 1'b0;
    first_wr_cyc = -1;
    done_cyc = -1;
    for (int i = 0; i < 1024; i++) layer1[i] = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 7000 && !done_seen; i++) @(negedge clk);
    chk("done_timeout", 32'(done_seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_t(input int target);
    int i;
    for (i = 0; i < 7000 && t < target; i++) @(negedge clk);
    chk("wait_t_timeout", 32'(t >= target), 32'd1);
  endtask

  task automatic fill_identity();
    for (int a = 0; a < 4096; a++) mem[a] = 20'(a);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 4096; a++) mem[a] = 20'($urandom);
  endtask

  task automatic check_identity_frame(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_writes"}, 32'(wr_count), 32'd1024);
    for (int oy = 0; oy < 32; oy++)
      for (int ox = 0; ox < 32; ox++)
        if (layer1[oy * 32 + ox] !== 20'((2 * oy + 1) * 64 + 2 * ox + 1)) bad++;
    chk({tag, "_layer1_bad_entries"}, 32'(bad), 32'd0);
    chk({tag, "_last_wr_addr"}, 32'(last_wr_addr), 32'd1023);
    chk({tag, "_last_wr_data"}, {12'd0, last_wr_data}, 32'd4095);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      first4[k] = '0;
      last4[k] = '0;
    end
    last_wr_addr = '0;
    last_wr_data = '0;
    fill_random();
    clear_log();

    // Reset with random inputs.
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_crd", 32'(crd), 32'd0);
      chk("rst_cwr", 32'(cwr), 32'd0);
      chk("rst_csel", 32'(csel), 32'd0);
      chk("rst_caddr_rd", 32'(caddr_rd), 32'd0);
      chk("rst_caddr_wr", 32'(caddr_wr), 32'd0);
      chk("rst_cdata_wr", {12'd0, cdata_wr}, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_writes", 32'(wr_count), 32'd0);
    chk("idle_reads", 32'(rd_count), 32'd0);

    // Single window {5, 9, 3, 7} in a random frame.
    fill_random();
    mem[0] = 20'd5; mem[1] = 20'd9; mem[64] = 20'd3; mem[65] = 20'd7;
    clear_log();
    pulse_start();
    wait_done();
    chk("sw_data", {12'd0, layer1[0]}, 32'd9);
    chk("sw_rd0", 32'(first4[0]), 32'd0);
    chk("sw_rd1", 32'(first4[1]), 32'd1);
    chk("sw_rd2", 32'(first4[2]), 32'd64);
    chk("sw_rd3", 32'(first4[3]), 32'd65);
    chk("sw_first_wr_latency", 32'(first_wr_cyc - frame_start), 32'd5);
    chk("sw_writes", 32'(wr_count), 32'd1024);

    // Full identity frame.
    fill_identity();
    clear_log();
    pulse_start();
    wait_done();
    check_identity_frame("full");
    chk("full_done_latency", 32'(done_cyc - frame_start), 32'd6144);

    // Sign, ties and maximum position.
    fill_random();
    mem[0] = 20'hFFFFC; mem[1] = 20'hFFFFE; mem[64] = 20'hFFFF8; mem[65] = 20'hFFFFD;
    mem[2] = 20'h7FFFF; mem[3] = 20'h80000; mem[66] = 20'h00000; mem[67] = 20'h00000;
    mem[4] = 20'h00123; mem[5] = 20'h00123; mem[68] = 20'h00123; mem[69] = 20'h00123;
    for (int k = 0; k < 4; k++) begin
      int a;
      a = 2 * (3 + k);
      mem[a] = 20'hF0000; mem[a + 1] = 20'hF0001; mem[a + 64] = 20'hF0002; mem[a + 65] = 20'hF0003;
      case (k)
        0: mem[a] = 20'h00500;
        1: mem[a + 1] = 20'h00501;
        2: mem[a + 64] = 20'h00502;
        default: mem[a + 65] = 20'h00503;
      endcase
    end
    clear_log();
    pulse_start();
    wait_done();
    chk("neg_max", {12'd0, layer1[0]}, 32'h000FFFFE);
    chk("pos_vs_min", {12'd0, layer1[1]}, 32'h0007FFFF);
    chk("all_equal", {12'd0, layer1[2]}, 32'h00000123);
    for (int k = 0; k < 4; k++) chk("max_position", {12'd0, layer1[3 + k]}, 32'h500 + 32'(k));
    chk("last_rd0", 32'(last4[0]), 32'd4030);
    chk("last_rd1", 32'(last4[1]), 32'd4031);
    chk("last_rd2", 32'(last4[2]), 32'd4094);
    chk("last_rd3", 32'(last4[3]), 32'd4095);

    // Stray starts, then reset in the middle of a frame.
    fill_identity();
    clear_log();
    pulse_start();
    wait_t(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_t(3000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_t(6 * 599 + 5);
    chk("pre_reset_in_write", 32'(cwr), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_log();
    repeat (50) @(negedge clk);
    chk("post_reset_writes", 32'(wr_count), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    pulse_start();
    wait_done();
    check_identity_frame("restart");
    chk("restart_done_latency", 32'(done_cyc - frame_start), 32'd6144);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
